pool_flatten: RTL and testbench
===============================

POOL_FLATTEN -- requirements
Module: pool_flatten

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the element width in bits.
REQ-002 SHALL have parameter FMAP_SIZE, default 4, the pooled feature-map edge length (matches CONV_OFMAP_SIZE/2).
REQ-003 SHALL have localparam NUM_ELEMS = FMAP_SIZE*FMAP_SIZE and IDX_W = $clog2(NUM_ELEMS), minimum 1.
REQ-004 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have pool_done  input  1  completion level from the maxpool stage; stays high once set.
REQ-007 SHALL have ifmap  input  DATA_WIDTH x [FMAP_SIZE][FMAP_SIZE]  the pooled feature map, valid while pool_done is high.
REQ-008 SHALL have m_valid  output  1  the stream element is valid.
REQ-009 SHALL have m_ready  input  1  the downstream consumer accepts the element.
REQ-010 SHALL have m_data  output  DATA_WIDTH  the current element.
REQ-011 SHALL have m_index  output  IDX_W  the row-major index of m_data (row*FMAP_SIZE+col).
REQ-012 SHALL have m_last  output  1  high with m_valid on element NUM_ELEMS-1.
REQ-013 SHALL have busy  output  1  high while a map is buffered and not fully streamed.
REQ-014 SHALL have done  output  1  one-cycle pulse after the final handshake.
REQ-015 SHALL have overrun  output  1  sticky flag: a start edge arrived while busy.

Function
REQ-016 SHALL register pool_done into pool_done_q each cycle; start = pool_done & ~pool_done_q.
REQ-017 SHALL implement states IDLE, STREAM, FINISH.
REQ-018 IDLE: on start, SHALL copy all of ifmap into an internal buffer, clear the row/col counters and go to STREAM the next cycle.
REQ-019 SHALL assert m_valid exactly in STREAM; first element (index 0) valid the cycle after the start cycle (latency 1).
REQ-020 SHALL drive m_data = buffer[row][col], m_index and m_last combinationally from the buffer and counters only; the ifmap input is not read after capture.
REQ-021 A handshake SHALL be m_valid & m_ready in the same cycle; without it m_data/m_index/m_last SHALL stay constant.
REQ-022 On a handshake with col < FMAP_SIZE-1 SHALL increment col; with col = FMAP_SIZE-1 SHALL clear col and increment row.
REQ-023 On the handshake of index NUM_ELEMS-1 SHALL go to FINISH; m_valid low the next cycle.
REQ-024 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in STREAM and FINISH, 0 in IDLE.
REQ-026 Back-to-back m_ready high SHALL sustain one element per cycle; NUM_ELEMS elements take NUM_ELEMS cycles.
REQ-027 A start while in STREAM or FINISH SHALL be ignored (buffer unchanged) and SHALL set overrun to 1.
REQ-028 overrun SHALL clear only by reset.
REQ-029 pool_done held high SHALL not retrigger; a new map requires pool_done to fall and rise again.
REQ-030 A start in the same cycle FINISH returns to IDLE SHALL count as overrun, not a new capture.

Reset
REQ-031 On reset SHALL go to IDLE, clear row/col, pool_done_q, overrun; outputs m_valid=0, m_last=0, busy=0, done=0, m_index=0.
REQ-032 Reset mid-stream SHALL abort the map with no done pulse; buffer contents are don't-care.
REQ-033 If pool_done is high when reset deasserts, pool_done_q=0 SHALL make the first post-reset cycle a start.

Verification
REQ-034 FMAP_SIZE=4, ifmap[r][c]=r*4+c, pool_done 0->1, m_ready=1 -> m_valid from next cycle, m_data 0..15 over 16 consecutive cycles, m_last only at 15, done pulse next cycle.
REQ-035 Same map, m_ready toggling 1,0,1,0 -> each element held stable while m_ready=0; 16 handshakes, order 0..15, no duplicates.
REQ-036 Change ifmap to all 8'hFF two cycles after start -> stream still 0..15.
REQ-037 pool_done 1->0->1 at element 5 -> overrun=1, stream continues 5..15 unchanged, overrun stays 1 after done.
REQ-038 reset at element 7 -> m_valid=0, busy=0 next cycle, no done; new start -> fresh stream from index 0.
REQ-039 pool_done held high 40 cycles after one stream -> exactly one done pulse, m_valid stays 0 after FINISH.

Source files
------------

// File: rtl/pool_flatten_if.sv
// Stream bus carrying flattened feature-map elements from pool_flatten to the
// downstream consumer. valid/ready handshake, plus element index and last marker.
interface pool_flatten_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [IDX_W-1:0]      m_index;
  logic                  m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/pool_flatten.sv
// Captures a pooled feature map on the rising edge of pool_done and streams it
// out row-major, one element per accepted handshake.
module pool_flatten #(
  parameter int DATA_WIDTH = 8,
  parameter int FMAP_SIZE  = 4
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                pool_done,
  input  logic [FMAP_SIZE-1:0][FMAP_SIZE-1:0][DATA_WIDTH-1:0] ifmap,
  pool_flatten_if.master                                      strm,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                overrun
);

  localparam int NUM_ELEMS = FMAP_SIZE * FMAP_SIZE;
  localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int RC_W      = (FMAP_SIZE > 1) ? $clog2(FMAP_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t          state_q, state_d;
  logic            pool_done_q;
  logic            start;
  logic            hs;
  logic            last_elem;
  logic [RC_W-1:0] row_q, col_q;
  logic [FMAP_SIZE-1:0][FMAP_SIZE-1:0][DATA_WIDTH-1:0] buf_q;

  assign start     = pool_done & ~pool_done_q;
  assign hs        = strm.m_valid & strm.m_ready;
  assign last_elem = (row_q == RC_W'(FMAP_SIZE - 1)) && (col_q == RC_W'(FMAP_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pool_done_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pool_done_q <= pool_done;
      // A new map while the previous one is still owned here is dropped, not queued.
      if (start && (state_q != IDLE))
        overrun <= 1'b1;
      if ((state_q == IDLE) && start) begin
        row_q <= '0;
        col_q <= '0;
      end else if (hs) begin
        if (col_q == RC_W'(FMAP_SIZE - 1)) begin
          col_q <= '0;
          row_q <= last_elem ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Snapshot of the map; the live ifmap is never read after this edge.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start)
      buf_q <= ifmap;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (hs && last_elem) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign strm.m_valid = (state_q == STREAM);
  assign strm.m_data  = buf_q[row_q][col_q];
  assign strm.m_index = IDX_W'(row_q * FMAP_SIZE + col_q);
  assign strm.m_last  = strm.m_valid & last_elem;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);

endmodule

// File: tb/tb_pool_flatten.sv
// Bench for pool_flatten: vector table for the basic stream, directed corner
// sequences, and randomized maps/back-pressure against a stream-level model.
module tb_pool_flatten;

  localparam int DW = 8;
  localparam int FS = 4;
  localparam int NE = FS * FS;
  localparam int IW = 4;

  typedef logic [FS-1:0][FS-1:0][DW-1:0] map_t;

  typedef struct {
    logic pd;
    logic rdy;
    logic valid;
    int   idx;
    logic last;
    logic busy;
    logic done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic pool_done;
  map_t ifmap;
  logic busy, done, overrun;

  int checks   = 0;
  int failures = 0;
  logic exp_ovr = 1'b0;

  pool_flatten_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus ();

  pool_flatten #(.DATA_WIDTH(DW), .FMAP_SIZE(FS)) dut (
    .clk       (clk),
    .reset     (reset),
    .pool_done (pool_done),
    .ifmap     (ifmap),
    .strm      (bus.master),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic map_t ramp_map();
    map_t m;
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < FS; c++)
        m[r][c] = DW'(r * FS + c);
    return m;
  endfunction

  function automatic map_t rand_map();
    map_t m;
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < FS; c++)
        m[r][c] = DW'($urandom);
    return m;
  endfunction

  // Create a fresh rising edge of pool_done with map presented on ifmap.
  task automatic launch(input map_t map);
    pool_done = 1'b0;
    tick();
    ifmap     = map;
    pool_done = 1'b1;
    chk("launch_idle_busy", busy, 0);
    tick();
  endtask

  // Model: the stream is exactly snap[k/FS][k%FS] for k = 0..NE-1, advancing on
  // each accepted cycle, followed by a single done cycle.
  // mode: 0 random ready, 1 always ready, 2 ready toggling 1,0,1,0...
  task automatic drain(input map_t snap, input int mode, input int glitch_at,
                       input int abort_at, input bit scramble);
    int k = 0;
    int cyc = 0;
    int gstate = 0;
    while (k < NE) begin
      if (cyc >= 200) begin
        chk("stream_timeout", k, NE);
        return;
      end
      case (mode)
        1:       bus.m_ready = 1'b1;
        2:       bus.m_ready = (cyc % 2 == 0);
        default: bus.m_ready = $urandom_range(0, 1) == 1;
      endcase
      if (scramble) ifmap = {$urandom, $urandom, $urandom, $urandom};
      if (k == glitch_at && gstate == 0) begin
        pool_done = 1'b0;
        gstate = 1;
      end else if (gstate == 1) begin
        pool_done = 1'b1;
        gstate = 2;
        exp_ovr = 1'b1;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        pool_done = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_ovr = 1'b0;
        chk("abort_valid", bus.m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_index", bus.m_index, 0);
        chk("abort_overrun", overrun, 0);
        return;
      end
      chk("stream_valid", bus.m_valid, 1);
      if (bus.m_valid !== 1'b1) return;
      chk("stream_data", bus.m_data, snap[k / FS][k % FS]);
      chk("stream_index", bus.m_index, k);
      chk("stream_last", bus.m_last, (k == NE - 1));
      chk("stream_busy", busy, 1);
      chk("stream_done", done, 0);
      if (bus.m_ready) k++;
      cyc++;
      tick();
    end
    if (mode == 1) chk("stream_cycles", cyc, NE);
    if (gstate == 1) begin
      pool_done = 1'b1;
      exp_ovr = 1'b1;
    end
    chk("finish_valid", bus.m_valid, 0);
    chk("finish_done", done, 1);
    chk("finish_busy", busy, 1);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", bus.m_valid, 0);
    chk("post_overrun", overrun, exp_ovr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[NE + 3];
    int dones;

    reset = 1'b1;
    pool_done = 1'b0;
    bus.m_ready = 1'b0;
    ifmap = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_index", bus.m_index, 0);
    chk("rst_overrun", overrun, 0);

    // Basic ramp stream with continuous ready.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= NE; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b1, i - 1, (i == NE), 1'b1, 1'b0};
    tbl[NE + 1] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
    tbl[NE + 2] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    ifmap = ramp_map();
    tick();
    for (int i = 0; i < NE + 3; i++) begin
      pool_done   = tbl[i].pd;
      bus.m_ready = tbl[i].rdy;
      chk("tbl_valid", bus.m_valid, tbl[i].valid);
      chk("tbl_last", bus.m_last, tbl[i].last);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_done", done, tbl[i].done);
      if (tbl[i].valid) begin
        chk("tbl_index", bus.m_index, tbl[i].idx);
        chk("tbl_data", bus.m_data, tbl[i].idx);
      end
      tick();
    end

    // pool_done stays high: no retrigger.
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      chk("hold_valid", bus.m_valid, 0);
      tick();
    end
    chk("hold_done_count", dones, 0);

    launch(ramp_map());
    drain(ramp_map(), 2, -1, -1, 1'b0);

    launch(ramp_map());
    drain(ramp_map(), 1, -1, -1, 1'b1);

    launch(ramp_map());
    drain(ramp_map(), 1, 5, -1, 1'b0);
    chk("overrun_sticky", overrun, 1);

    // Start edge landing on the FINISH cycle: overrun only, no capture.
    launch(ramp_map());
    drain(ramp_map(), 1, NE - 1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("fin_start_busy", busy, 0);
      chk("fin_start_valid", bus.m_valid, 0);
      tick();
    end

    launch(rand_map());
    drain(ifmap, 1, -1, 7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 0);
      tick();
    end
    launch(ramp_map());
    drain(ramp_map(), 1, -1, -1, 1'b0);

    // pool_done already high as reset releases: first cycle is a start.
    ifmap = rand_map();
    pool_done = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ovr = 1'b0;
    chk("rel_idle_valid", bus.m_valid, 0);
    begin
      map_t snap;
      snap = ifmap;
      tick();
      drain(snap, 0, -1, -1, 1'b1);
    end

    for (int n = 0; n < 20; n++) begin
      map_t m;
      int g;
      m = rand_map();
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NE - 2)) : -1;
      launch(m);
      drain(m, 0, g, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
